// File: rtl/ifu_fetch.sv
// Instruction fetch stage.
// Holds the fetch PC and issues in-order word requests to instruction memory.
// Responses are matched to a queue of request PCs and buffered in a small FIFO
// that feeds decode through a valid/ready handshake.
// A redirect restarts fetch at a new target. It also flushes the buffer and
// discards every response that is still in flight.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC        = 32'h0000_3000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_ins,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]      fetch_pc;
   logic [31:0]      tag_mem [MAX_OUTSTANDING];
   logic [TAG_W-1:0] tag_wr;
   logic [TAG_W-1:0] tag_rd;
   logic [OUT_W-1:0] outstanding;
   logic [OUT_W-1:0] outstanding_nxt;
   logic [OUT_W-1:0] drop_cnt;

   logic [31:0]      fifo_ins [FIFO_DEPTH];
   logic [31:0]      fifo_pc  [FIFO_DEPTH];
   logic [PTR_W-1:0] fifo_wr;
   logic [PTR_W-1:0] fifo_rd;
   logic [CNT_W-1:0] fifo_count;

   logic [31:0]      credit_used;
   logic             issue_ok;
   logic             grant;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic [31:0]      head_tag;
   logic [31:0]      redirect_target;

   // Advance a tag queue pointer, wrapping at MAX_OUTSTANDING entries.
   function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
      if (p == TAG_W'(MAX_OUTSTANDING - 1)) return '0;
      else return p + TAG_W'(1);
   endfunction

   // Responses that will be dropped do not consume buffer space.
   // The request is therefore gated by the live requests plus the entries
   // already buffered.
   assign credit_used     = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);
   assign issue_ok        = (credit_used < 32'(FIFO_DEPTH)) &&
                            (32'(outstanding) < 32'(MAX_OUTSTANDING));
   assign imem_req        = !rst && !redirect && issue_ok;
   assign imem_addr       = fetch_pc;
   assign grant           = imem_req && imem_gnt;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign head_tag        = tag_mem[tag_rd];

   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign fifo_push = imem_rvalid && !redirect && (drop_cnt == '0);
   assign fifo_pop  = id_valid && id_ready && !redirect;
   assign id_valid  = (fifo_count != '0);
   assign id_ins    = fifo_ins[fifo_rd];
   assign id_pc     = fifo_pc[fifo_rd];

   // Net change in in-flight requests: a grant adds one and a response retires one.
   always_comb begin
      outstanding_nxt = outstanding;
      if (grant && !imem_rvalid)
         outstanding_nxt = outstanding + OUT_W'(1);
      else if (!grant && imem_rvalid)
         outstanding_nxt = outstanding - OUT_W'(1);
   end

   // Fetch PC steps by one word per grant. A redirect loads the aligned target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_pc <= RESET_PC;
      else if (redirect)
         fetch_pc <= redirect_target;
      else if (grant)
         fetch_pc <= fetch_pc + 32'd4;
   end

   // The tag queue records the PC of each granted request until its response returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         outstanding <= '0;
      end else begin
         if (grant) begin
            tag_mem[tag_wr] <= fetch_pc;
            tag_wr          <= tag_next(tag_wr);
         end
         if (imem_rvalid)
            tag_rd <= tag_next(tag_rd);
         outstanding <= outstanding_nxt;
      end
   end

   // On a redirect, every request still in flight belongs to the old path and must be discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_cnt <= '0;
      else if (redirect)
         drop_cnt <= outstanding_nxt;
      else if (imem_rvalid && (drop_cnt != '0))
         drop_cnt <= drop_cnt - OUT_W'(1);
   end

   // The instruction buffer is a circular FIFO. It is flushed wholesale on a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_ins[i] <= '0;
            fifo_pc[i]  <= '0;
         end
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else if (redirect) begin
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            fifo_ins[fifo_wr] <= imem_rdata;
            fifo_pc[fifo_wr]  <= head_tag;
            fifo_wr           <= fifo_wr + PTR_W'(1);
         end
         if (fifo_pop)
            fifo_rd <= fifo_rd + PTR_W'(1);
         if (fifo_push && !fifo_pop)
            fifo_count <= fifo_count + CNT_W'(1);
         else if (!fifo_push && fifo_pop)
            fifo_count <= fifo_count - CNT_W'(1);
      end
   end

   // The credit rule should make overflow impossible.
   // A push into a full buffer without a simultaneous pop is a design error.
   assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch.
// It uses a behavioural instruction memory with a one-cycle response and an optional response hold.
// Monitors log granted addresses and decoded (pc, ins) pairs.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_valid;
   logic [31:0] id_ins;
   logic [31:0] id_pc;
   logic        id_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   logic        mem_hold = 1'b0;
   logic        mem_g;
   logic [31:0] mem_a;
   logic [31:0] rv_addr = '0;
   logic [31:0] mem_q[$];
   logic [31:0] req_log[$];
   logic [31:0] pc_log[$];
   logic [31:0] ins_log[$];

   ifu_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ins     (id_ins),
      .id_pc      (id_pc),
      .id_ready   (id_ready)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Instruction memory contents: a distinctive function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Memory model.
   // Each grant is captured at the clock edge and answered in order during the following cycle,
   // unless responses are being held.
   always begin
      @(posedge clk);
      mem_g = imem_req & imem_gnt & !rst;
      mem_a = imem_addr;
      #1;
      if (rst) begin
         mem_q.delete();
         imem_rvalid = 1'b0;
      end else begin
         if (mem_g) mem_q.push_back(mem_a);
         if (!mem_hold && mem_q.size() > 0) begin
            rv_addr     = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rv_addr);
         end else begin
            imem_rvalid = 1'b0;
         end
      end
   end

   // Log every granted address and every instruction decode actually consumes.
   // A pop during a redirect does not count as consumed.
   always @(posedge clk) begin
      if (!rst) begin
         if (imem_req && imem_gnt) req_log.push_back(imem_addr);
         if (id_valid && id_ready && !redirect) begin
            pc_log.push_back(id_pc);
            ins_log.push_back(id_ins);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   // Hold reset for two cycles, clear the logs and release at a falling edge with the given handshake levels.
   task automatic do_reset(input logic gnt, input logic rdy);
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; mem_hold = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
      repeat (2) @(negedge clk);
      req_log.delete(); pc_log.delete(); ins_log.delete();
      imem_gnt = gnt; id_ready = rdy; rst = 1'b0;
   endtask

   // Reset values, then the first request at RESET_PC, which holds while no grant is given.
   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", id_valid); end
      checks++; if (id_ins !== 32'h0) begin failures++; $display("[TB] FAIL reset_ins got=%h exp=0", id_ins); end
      checks++; if (id_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", id_pc); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin failures++; $display("[TB] FAIL first_req got=%b/%h exp=1/00003000", imem_req, imem_addr); end
      repeat (3) @(negedge clk);
      checks++; if (imem_addr !== 32'h0000_3000) begin failures++; $display("[TB] FAIL no_gnt_hold got=%h exp=00003000", imem_addr); end
   endtask

   // Free-flowing stream: sequential addresses and PCs, instructions matching memory, sustained delivery.
   task automatic test_stream();
      do_reset(1'b1, 1'b1);
      repeat (30) @(negedge clk);
      checks++;
      if (req_log.size() < 8 || pc_log.size() < 8) begin
         failures++; $display("[TB] FAIL stream_len got=%0d/%0d exp>=8", req_log.size(), pc_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (req_log[i] !== 32'h3000 + 32'(4 * i)) begin failures++; $display("[TB] FAIL stream_addr%0d got=%h exp=%h", i, req_log[i], 32'h3000 + 32'(4 * i)); end
            checks++; if (pc_log[i] !== 32'h3000 + 32'(4 * i)) begin failures++; $display("[TB] FAIL stream_pc%0d got=%h exp=%h", i, pc_log[i], 32'h3000 + 32'(4 * i)); end
            checks++; if (ins_log[i] !== mem_word(pc_log[i])) begin failures++; $display("[TB] FAIL stream_ins%0d got=%h exp=%h", i, ins_log[i], mem_word(pc_log[i])); end
         end
      end
      checks++; if (pc_log.size() < 15) begin failures++; $display("[TB] FAIL stream_rate got=%0d exp>=15", pc_log.size()); end
   endtask

   // Decode stalled for 10 cycles: two requests fill the buffer, the head holds, nothing is lost on release.
   task automatic test_stall();
      do_reset(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h0000_3000 || id_ins !== mem_word(32'h0000_3000)) begin
               failures++; $display("[TB] FAIL stall_hold%0d got=%b/%h/%h exp=1/00003000/%h", i, id_valid, id_pc, id_ins, mem_word(32'h0000_3000));
            end
         end
      end
      checks++; if (req_log.size() != 2) begin failures++; $display("[TB] FAIL stall_reqs got=%0d exp=2", req_log.size()); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_low got=%b exp=0", imem_req); end
      id_ready = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (pc_log.size() < 3) begin
         failures++; $display("[TB] FAIL stall_release_len got=%0d exp>=3", pc_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (pc_log[i] !== 32'h3000 + 32'(4 * i)) begin failures++; $display("[TB] FAIL stall_pc%0d got=%h exp=%h", i, pc_log[i], 32'h3000 + 32'(4 * i)); end
            checks++; if (ins_log[i] !== mem_word(32'h3000 + 32'(4 * i))) begin failures++; $display("[TB] FAIL stall_ins%0d got=%h exp=%h", i, ins_log[i], mem_word(32'h3000 + 32'(4 * i))); end
         end
      end
   endtask

   // Redirect while two requests are outstanding: both stale responses are dropped and fetch resumes at 4010.
   task automatic test_redirect_drop();
      logic stale_seen;
      do_reset(1'b1, 1'b1);
      mem_hold = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (req_log.size() != 2 || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL drop_pre got=%0d/%b exp=2/0", req_log.size(), imem_req); end
      redirect = 1'b1; redirect_pc = 32'h0000_4010;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL drop_req_in_redirect got=%b exp=0", imem_req); end
      @(negedge clk);
      redirect = 1'b0; mem_hold = 1'b0;
      req_log.delete(); pc_log.delete(); ins_log.delete();
      repeat (20) @(negedge clk);
      checks++;
      if (pc_log.size() < 2 || req_log.size() < 1) begin
         failures++; $display("[TB] FAIL drop_len got=%0d/%0d exp>=2/1", pc_log.size(), req_log.size());
      end else begin
         checks++; if (req_log[0] !== 32'h0000_4010) begin failures++; $display("[TB] FAIL drop_addr0 got=%h exp=00004010", req_log[0]); end
         checks++; if (pc_log[0] !== 32'h0000_4010) begin failures++; $display("[TB] FAIL drop_pc0 got=%h exp=00004010", pc_log[0]); end
         checks++; if (pc_log[1] !== 32'h0000_4014) begin failures++; $display("[TB] FAIL drop_pc1 got=%h exp=00004014", pc_log[1]); end
         checks++; if (ins_log[0] !== mem_word(32'h0000_4010)) begin failures++; $display("[TB] FAIL drop_ins0 got=%h exp=%h", ins_log[0], mem_word(32'h0000_4010)); end
      end
      stale_seen = 1'b0;
      foreach (pc_log[i]) if (pc_log[i] < 32'h0000_4010) stale_seen = 1'b1;
      checks++; if (stale_seen !== 1'b0) begin failures++; $display("[TB] FAIL drop_stale got=%b exp=0", stale_seen); end
   endtask

   // Redirect in a cycle that also carries a response and a decode pop.
   // The buffer empties at once, the next request is the target, and the response that arrived is never seen.
   task automatic test_redirect_rvalid();
      logic        found;
      logic        stale_seen;
      logic [31:0] stale;
      do_reset(1'b1, 1'b1);
      repeat (4) @(negedge clk);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (imem_rvalid && id_valid) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++; $display("[TB] FAIL rv_find got=0 exp=1");
      end else begin
         stale = rv_addr;
         redirect = 1'b1; redirect_pc = 32'h0000_5000;
         @(negedge clk);
         redirect = 1'b0;
         req_log.delete(); pc_log.delete(); ins_log.delete();
         #1;
         checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL rv_flush got=%b exp=0", id_valid); end
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_5000) begin failures++; $display("[TB] FAIL rv_next_req got=%b/%h exp=1/00005000", imem_req, imem_addr); end
         repeat (15) @(negedge clk);
         checks++;
         if (pc_log.size() < 2) begin
            failures++; $display("[TB] FAIL rv_len got=%0d exp>=2", pc_log.size());
         end else begin
            checks++; if (pc_log[0] !== 32'h0000_5000) begin failures++; $display("[TB] FAIL rv_pc0 got=%h exp=00005000", pc_log[0]); end
            checks++; if (pc_log[1] !== 32'h0000_5004) begin failures++; $display("[TB] FAIL rv_pc1 got=%h exp=00005004", pc_log[1]); end
         end
         stale_seen = 1'b0;
         foreach (pc_log[i]) if (pc_log[i] == stale) stale_seen = 1'b1;
         checks++; if (stale_seen !== 1'b0) begin failures++; $display("[TB] FAIL rv_stale got=%b exp=0 pc=%h", stale_seen, stale); end
      end
   endtask

   // Unaligned redirect near the top of memory.
   // The target is aligned down and the address wraps to zero.
   task automatic test_wrap();
      logic [31:0] exp_a [3];
      exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0000_0000; exp_a[2] = 32'h0000_0004;
      do_reset(1'b1, 1'b1);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      redirect = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (req_log.size() < 3 || pc_log.size() < 3) begin
         failures++; $display("[TB] FAIL wrap_len got=%0d/%0d exp>=3", req_log.size(), pc_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (req_log[i] !== exp_a[i]) begin failures++; $display("[TB] FAIL wrap_addr%0d got=%h exp=%h", i, req_log[i], exp_a[i]); end
            checks++; if (pc_log[i] !== exp_a[i]) begin failures++; $display("[TB] FAIL wrap_pc%0d got=%h exp=%h", i, pc_log[i], exp_a[i]); end
            checks++; if (ins_log[i] !== mem_word(exp_a[i])) begin failures++; $display("[TB] FAIL wrap_ins%0d got=%h exp=%h", i, ins_log[i], mem_word(exp_a[i])); end
         end
      end
   endtask

   // Reset asserted mid-cycle with grants stalled.
   // Outputs clear immediately, and fetch restarts at RESET_PC.
   task automatic test_reset_mid();
      do_reset(1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_valid got=%b exp=1", id_valid); end
      imem_gnt = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_req got=%b exp=0", imem_req); end
      checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%b exp=0", id_valid); end
      repeat (2) @(negedge clk);
      req_log.delete(); pc_log.delete(); ins_log.delete();
      imem_gnt = 1'b1; id_ready = 1'b1; rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin failures++; $display("[TB] FAIL mid_restart got=%b/%h exp=1/00003000", imem_req, imem_addr); end
      repeat (6) @(negedge clk);
      checks++;
      if (req_log.size() < 1 || pc_log.size() < 1) begin
         failures++; $display("[TB] FAIL mid_len got=%0d/%0d exp>=1", req_log.size(), pc_log.size());
      end else begin
         checks++; if (req_log[0] !== 32'h0000_3000) begin failures++; $display("[TB] FAIL mid_addr0 got=%h exp=00003000", req_log[0]); end
         checks++; if (pc_log[0] !== 32'h0000_3000) begin failures++; $display("[TB] FAIL mid_pc0 got=%h exp=00003000", pc_log[0]); end
      end
   endtask

   // Run every scenario in sequence, then report.
   initial begin
      #1 rst = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_rvalid();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
